// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants for the buffered UART transmitter: parity
//                mode encodings and the transmit FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Parity mode encodings used by the PARITY parameter
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Transmit FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo
//  Description : Synchronous word FIFO with registered full/empty/level flags
//                and fall-through output (head word visible while not empty).
//                Pushes while full and pops while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_LEVEL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             w_wr, w_rd;

  assign w_wr = push & ~full_q;
  assign w_rd = pop  & ~empty_q;

  // Pointer and occupancy update; flags are derived from the next level so they stay registered
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (w_wr) wptr_d = wptr_q + AW'(1);
    if (w_rd) rptr_d = rptr_q + AW'(1);
    case ({w_wr, w_rd})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == C_LEVEL_FULL);
    empty_d = (level_d == '0);
  end

  // Control registers; reset flushes the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wptr_q] <= din;
  end

  assign dout  = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_buffered
//  Description : FIFO-buffered UART transmitter with configurable data width,
//                parity and stop bits. Frames are sent back-to-back while the
//                FIFO holds words. TxD and Tx_done are registered outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          transmit,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          TxD,
  output logic                          Tx_done
);

  localparam int             CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  C_BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     C_DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]     C_STOP_LAST  = 4'(STOP_BITS - 1);
  localparam bit             C_HAS_PARITY = (PARITY != PARITY_NONE);

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   txd_q, txd_d;
  logic                   done_q, done_d;
  logic                   ovf_q;

  logic                   w_pop;
  logic                   w_bit_end;
  logic                   w_word_par;
  logic [DATA_BITS-1:0]   w_head;
  logic                   w_empty;
  logic                   w_full;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (transmit),
    .pop   (w_pop),
    .din   (data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  assign w_bit_end  = (cnt_q == C_BIT_LAST);
  assign w_word_par = (PARITY == PARITY_ODD) ? ~^w_head : ^w_head;

  // State register plus datapath registers for the serialiser
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      ovf_q   <= transmit & w_full;
    end
  end

  // Next-state logic: bit timing, bit index, shifting and FIFO pop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    w_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          shift_d = w_head;
          par_d   = w_word_par;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == C_DATA_LAST) begin
            bit_d   = '0;
            state_d = C_HAS_PARITY ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          cnt_d = '0;
          if (bit_q == C_STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next frame when a word is waiting
            if (!w_empty) begin
              w_pop   = 1'b1;
              shift_d = w_head;
              par_d   = w_word_par;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Output logic: line level and end-of-frame flag for the upcoming cycle
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = par_d;
      default:   txd_d = 1'b1;
    endcase
    done_d = (state_d == ST_STOP) && (cnt_d == C_BIT_LAST) && (bit_d == C_STOP_LAST);
  end

  assign full     = w_full;
  assign overflow = ovf_q;
  assign busy     = (state_q != ST_IDLE);
  assign TxD      = txd_q;
  assign Tx_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_buffered
//  Description : Scoreboard bench for uart_tx_buffered. Four instances cover
//                the default frame, even/odd parity and a 7-bit/2-stop frame.
//                Written words go into per-instance queues; serial monitors
//                decode TxD and compare every frame against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic [6:0] d3 = '0;
  logic [3:0] tr = '0;
  wire  [3:0] f, ov, bz, tx, dn;
  wire  [2:0] lv0, lv1, lv2, lv3;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int nfr  [4] = '{0, 0, 0, 0};
  int dlen [4] = '{0, 0, 0, 0};
  logic [12:0] capv [4];
  int dt0 [64];

  logic [8:0] q0[$], q1[$], q2[$], q3[$];

  uart_tx_buffered u_dut0 (
    .clk(clk), .reset(reset), .data(d0), .transmit(tr[0]), .full(f[0]), .level(lv0),
    .overflow(ov[0]), .busy(bz[0]), .TxD(tx[0]), .Tx_done(dn[0]));

  uart_tx_buffered #(.PARITY(2)) u_dut1 (
    .clk(clk), .reset(reset), .data(d1), .transmit(tr[1]), .full(f[1]), .level(lv1),
    .overflow(ov[1]), .busy(bz[1]), .TxD(tx[1]), .Tx_done(dn[1]));

  uart_tx_buffered #(.PARITY(1)) u_dut2 (
    .clk(clk), .reset(reset), .data(d2), .transmit(tr[2]), .full(f[2]), .level(lv2),
    .overflow(ov[2]), .busy(bz[2]), .TxD(tx[2]), .Tx_done(dn[2]));

  uart_tx_buffered #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .reset(reset), .data(d3), .transmit(tr[3]), .full(f[3]), .level(lv3),
    .overflow(ov[3]), .busy(bz[3]), .TxD(tx[3]), .Tx_done(dn[3]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard queues ----------------
  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [8:0] qpop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  task automatic qpush(input int k, input logic [8:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  task automatic qclear();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // ---------------- serial monitor ----------------
  task automatic mon(input int k, input int db, input int par, input int sb);
    int nb, len, bad, firstbad, dl, pc;
    bit aborted;
    logic [12:0] bits, cap;
    logic [8:0] w;
    logic p;
    nb  = 1 + db + ((par != 0) ? 1 : 0) + sb;
    len = nb * CPB;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (dn[k] !== 1'b0) begin
        nvec++; nerr++;
        $display("FAIL done_idle_dut%0d: Tx_done=%b outside a frame, expected 0", k, dn[k]);
      end
      if (tx[k] === 1'b0) begin
        if (qsize(k) == 0) begin
          nvec++; nerr++;
          $display("FAIL spurious_frame_dut%0d: frame started with %0d words expected, expected none", k, 0);
          w = '0;
        end else begin
          w = qpop(k);
        end
        bits = '1;
        bits[0] = 1'b0;
        p = 1'b0;
        for (int j = 0; j < db; j++) begin
          bits[1+j] = w[j];
          p = p ^ w[j];
        end
        if (par == 1) bits[1+db] = ~p;
        if (par == 2) bits[1+db] = p;
        bad = 0; firstbad = -1; dl = 0; aborted = 1'b0; cap = '0;
        for (int i = 0; i < len; i++) begin
          if (i > 0) @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          pc = i / CPB;
          if ((i % CPB) == CPB/2) cap[pc] = tx[k];
          if (dn[k] === 1'b1 && dl == 0) dl = i + 1;
          if (tx[k] !== bits[pc] || dn[k] !== (i == len-1) || bz[k] !== 1'b1) begin
            bad++;
            if (firstbad < 0) firstbad = i;
          end
        end
        if (!aborted) begin
          nvec++;
          if (bad != 0) begin
            nerr++;
            $display("FAIL frame_dut%0d: word 0x%0h has %0d bad cycles (first at %0d), required 0", k, w, bad, firstbad);
          end
          capv[k] = cap;
          dlen[k] = dl;
          if (k == 0 && nfr[0] < 64) dt0[nfr[0]] = cyc;
          nfr[k]++;
        end
      end
    end
  endtask

  initial mon(0, 8, 0, 1);
  initial mon(1, 8, 2, 1);
  initial mon(2, 8, 1, 1);
  initial mon(3, 7, 2, 2);

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int k, input logic [8:0] v, input bit acc);
    case (k)
      0: d0 = v[7:0];
      1: d1 = v[7:0];
      2: d2 = v[7:0];
      default: d3 = v[6:0];
    endcase
    tr[k] = 1'b1;
    if (acc) qpush(k, v);
  endtask

  task automatic wr1(input int k, input logic [8:0] v);
    drive(k, v, 1'b1);
    @(posedge clk); #1;
    tr[k] = 1'b0;
  endtask

  task automatic wait_frames(input int k, input int n, input int budget);
    int t;
    t = 0;
    while (nfr[k] < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("frames_reached_dut%0d", k), nfr[k], n);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin : stim
    int base, cnt;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_TxD",      int'(tx[0]), 1);
    chk("rst_Tx_done",  int'(dn[0]), 0);
    chk("rst_busy",     int'(bz[0]), 0);
    chk("rst_overflow", int'(ov[0]), 0);
    chk("rst_full",     int'(f[0]),  0);
    chk("rst_level",    int'(lv0),   0);
    @(posedge clk); #1;

    // Single 0x41 frame
    wr1(0, 9'h41);
    wait_frames(0, 1, 400);
    chk("t1_bits",  int'(capv[0][9:0]), 'h282);
    chk("t1_dlen",  dlen[0], 160);
    repeat (2) @(negedge clk);
    chk("t1_busy_after", int'(bz[0]), 0);

    // Four back-to-back words
    @(posedge clk); #1;
    base = nfr[0];
    drive(0, 9'h00, 1'b1); @(posedge clk); #1;
    drive(0, 9'hFF, 1'b1); @(posedge clk); #1;
    drive(0, 9'h55, 1'b1); @(posedge clk); #1;
    drive(0, 9'hA5, 1'b1); @(posedge clk); #1;
    tr[0] = 1'b0;
    @(negedge clk);
    chk("t2_peak_level", int'(lv0), 3);
    wait_frames(0, base + 4, 1200);
    for (int j = 1; j < 4; j++)
      chk($sformatf("t2_done_spacing%0d", j), dt0[base+j] - dt0[base+j-1], 160);
    repeat (4) @(negedge clk);

    // Hold transmit six cycles into a depth-4 FIFO
    @(posedge clk); #1;
    base = nfr[0];
    for (int i = 1; i <= 6; i++) begin
      drive(0, 9'(i), i <= 5);
      @(posedge clk); #1;
    end
    tr[0] = 1'b0;
    @(negedge clk);
    chk("t3_full",     int'(f[0]),  1);
    chk("t3_level",    int'(lv0),   4);
    chk("t3_overflow", int'(ov[0]), 1);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (ov[0] === 1'b1) cnt++;
    end
    chk("t3_overflow_once", cnt, 0);
    wait_frames(0, base + 5, 1500);
    repeat (300) @(negedge clk);
    chk("t3_frame_count", nfr[0], base + 5);
    chk("t3_idle_busy",   int'(bz[0]), 0);

    // Reset during data bit 3 with two words queued
    @(posedge clk); #1;
    base = nfr[0];
    drive(0, 9'h33, 1'b1); @(posedge clk); #1;
    drive(0, 9'h44, 1'b1); @(posedge clk); #1;
    drive(0, 9'h55, 1'b1); @(posedge clk); #1;
    tr[0] = 1'b0;
    @(negedge clk);
    chk("t6_level_before", int'(lv0), 2);
    repeat (70) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    qclear();
    @(negedge clk);
    chk("t6_TxD",   int'(tx[0]), 1);
    chk("t6_level", int'(lv0),   0);
    chk("t6_busy",  int'(bz[0]), 0);
    chk("t6_full",  int'(f[0]),  0);
    repeat (300) @(negedge clk);
    chk("t6_no_frames", nfr[0], base);
    @(posedge clk); #1;
    wr1(0, 9'h41);
    wait_frames(0, base + 1, 400);
    chk("t6_bits", int'(capv[0][9:0]), 'h282);
    chk("t6_dlen", dlen[0], 160);

    // Even parity
    wr1(1, 9'h41);
    wait_frames(1, 1, 400);
    chk("t4_even_41_par", int'(capv[1][9]), 0);
    chk("t4_even_dlen",   dlen[1], 176);
    @(posedge clk); #1;
    wr1(1, 9'h07);
    wait_frames(1, 2, 400);
    chk("t4_even_07_par", int'(capv[1][9]), 1);

    // Odd parity
    wr1(2, 9'h41);
    wait_frames(2, 1, 400);
    chk("t4_odd_41_par", int'(capv[2][9]), 1);
    chk("t4_odd_dlen",   dlen[2], 176);

    // 7 data bits, 2 stop bits
    wr1(3, 9'h41);
    wait_frames(3, 1, 400);
    chk("t5_bits", int'(capv[3][10:0]), 'h682);
    chk("t5_dlen", dlen[3], 176);

    repeat (20) @(negedge clk);
    chk("end_q0_empty", qsize(0), 0);
    chk("end_q1_empty", qsize(1), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
